volume_ramp: RTL

- Gain smoother that sits directly upstream of the stereo volume multiplier and drives its unsigned Volume control word.
- Steps Volume toward a register/encoder-supplied target by STEP counts every DIV sample strobes, so gain changes never jump and cause zipper noise.
- Provides soft mute: fades to 0, holds there, then fades back to the target on release.

---
 rtl/volume_ramp_pkg.sv | 6 +
 rtl/ramp_tick_div.sv | 43 ++++
 rtl/volume_ramp.sv | 71 +++++++
 3 files changed

// File: rtl/volume_ramp_pkg.sv
// volume_ramp_pkg: shared ramp state encoding and sizing constants for the volume smoother.
package volume_ramp_pkg;
    typedef enum logic [1:0] {IDLE, UP, DOWN, MUTED} ramp_state_t;
    localparam int DIV_W       = 16;
    localparam int VOL_BIT_DEF = 8;
endpackage

// File: rtl/ramp_tick_div.sv
// ramp_tick_div: divides sample strobes into ramp ticks; with VOLUME_RAMP_ZC_EN a due tick
// is held until the sign of the sampled audio flips between strobes.
module ramp_tick_div
    import volume_ramp_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic sample_en,
    input  logic clear,
    input  logic zc_sign,
    output logic tick
);
    logic [DIV_W-1:0] cnt;
    logic             last;
    logic             fire;

    assign last = cnt == DIV_W'(DIV - 1);

`ifdef VOLUME_RAMP_ZC_EN
    logic prev_sign;
    assign fire = zc_sign != prev_sign;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) prev_sign <= 1'b0;
        else if (sample_en) prev_sign <= zc_sign;
    end
`else
    logic zc_unused;
    assign zc_unused = zc_sign;
    assign fire      = 1'b1;
`endif

    assign tick = sample_en && !clear && last && fire;

    // A due tick waiting for a crossing leaves the count parked at DIV-1.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (sample_en && !last) cnt <= cnt + 1'b1;
        else if (tick) cnt <= '0;
    end
endmodule

// File: rtl/volume_ramp.sv
// volume_ramp: steps the multiplier's Volume toward target (or 0 under mute) by STEP per tick.
// Optional zero-cross gating of ticks is enabled by defining VOLUME_RAMP_ZC_EN.
module volume_ramp
    import volume_ramp_pkg::*;
#(
    parameter int VOL_BIT   = VOL_BIT_DEF,
    parameter int STEP      = 1,
    parameter int DIV       = 1,
    parameter int RESET_VOL = 0
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               sample_en,
    input  logic [VOL_BIT-1:0] target,
    input  logic               mute,
    input  logic               zc_sign,
    output logic [VOL_BIT-1:0] Volume,
    output logic               busy,
    output logic               muted
);
    localparam int VW = VOL_BIT + 1;

    ramp_state_t        state, next_state;
    logic [VOL_BIT-1:0] eff, vol_next, up_vol, dn_vol;
    logic [VOL_BIT:0]   up_sum, dn_diff;
    logic               tick, clear;

    assign eff   = mute ? '0 : target;
    assign clear = !(state == UP || state == DOWN);

    // One extra bit catches both overflow past the top and borrow below 0.
    assign up_sum  = {1'b0, Volume} + VW'(STEP);
    assign dn_diff = {1'b0, Volume} - VW'(STEP);
    assign up_vol  = (up_sum > {1'b0, eff}) ? eff : up_sum[VOL_BIT-1:0];
    assign dn_vol  = (dn_diff[VOL_BIT] || dn_diff < {1'b0, eff}) ? eff : dn_diff[VOL_BIT-1:0];

    ramp_tick_div #(.DIV(DIV)) u_div (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .sample_en (sample_en),
        .clear     (clear),
        .zc_sign   (zc_sign),
        .tick      (tick)
    );

    always_comb begin
        next_state = mute ? MUTED : IDLE;
        vol_next   = Volume;
        if (Volume < eff) begin
            next_state = UP;
            vol_next   = tick ? up_vol : Volume;
        end else if (Volume > eff) begin
            next_state = DOWN;
            vol_next   = tick ? dn_vol : Volume;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Volume <= VOL_BIT'(RESET_VOL);
            state  <= IDLE;
            busy   <= 1'b0;
            muted  <= 1'b0;
        end else begin
            Volume <= vol_next;
            state  <= next_state;
            busy   <= next_state == UP || next_state == DOWN;
            muted  <= next_state == MUTED;
        end
    end
endmodule
